vending_machine_change: RTL
===========================

Name: vending_machine_change

Overview:
- Parametrised successor of the single-product nickel/dime vending controller.
- Accepts nickel, dime and quarter coins plus a cancel button, all raw and mechanical. Each input is debounced and edge-detected internally.
- Tracks credit in nickel units, vends when credit reaches PRICE, then returns change as a train of nickel pulses.
- Sits between the board buttons and the dispense/return actuator LEDs. Runs on the divided clock.

Parameters:
- PRICE, 3, product price in nickel units (3 = 15 cents); legal range 1..2**CW-6.
- CW, 6, credit register width in bits.
- DB_CYCLES, 4, consecutive stable samples required before a debounced level changes; must be ≥1.
- CHANGE_GAP, 2, cycles between successive change pulses; must be ≥2.

Ports:
- clk  in  1  divided system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- nb  in  1  raw nickel button/coin sensor.
- db  in  1  raw dime button/coin sensor.
- qb  in  1  raw quarter button/coin sensor.
- cb  in  1  raw cancel button.
- s  out  1  vend strobe, one cycle per product.
- r  out  1  change strobe, one cycle per nickel returned.
- coin_reject  out  1  one-cycle pulse when an accepted coin edge is refused.
- credit  out  CW  current credit in nickel units.
- busy  out  1  high in VEND and CHANGE.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; s=0, r=0, coin_reject=0, credit=0, busy=0.
  - Synchronisers, debounce counters and edge-detect history are cleared to 0.
- Input conditioning, per input:
  - 2-flop synchroniser, then debounce counter. The clean level flips only after DB_CYCLES consecutive samples differ from it.
  - Rising edge of the clean level gives a one-cycle pulse (np, dp, qp, cp).
  - Latency from a stable raw input to the pulse: 2 + DB_CYCLES cycles.
  - A held button produces exactly one pulse.
- Coin value: vin = np*1 + dp*2 + qp*5. Simultaneous coin pulses in the same cycle are summed, not prioritised.
- States:
  - IDLE: credit=0. vin>0 → credit<=vin; go to VEND if vin≥PRICE, else COLLECT.
  - COLLECT:
    - cp=1 takes priority over coins: any coin pulses that cycle raise coin_reject, and the state goes to CHANGE with credit unchanged.
    - Otherwise credit<=credit+vin; go to VEND when credit+vin≥PRICE.
    - The sum is computed CW+1 wide. If it would exceed 2**CW-1, the coin is refused: coin_reject=1 and credit is held.
  - VEND (1 cycle):
    - s=1 and credit<=credit-PRICE.
    - Next state is CHANGE if credit-PRICE>0, else IDLE.
  - CHANGE:
    - r=1 on the first cycle, then every CHANGE_GAP cycles; each r pulse decrements credit by 1.
    - After the pulse that brings credit to 0, go to IDLE on the next cycle.
    - Cancel is ignored.
- Coins arriving in VEND or CHANGE are refused: coin_reject=1 for that cycle and credit is unaffected.
- Outputs are registered; s, r and coin_reject are never high for more than one consecutive cycle.
- Vend latency: the cycle after the coin pulse that crosses PRICE.
- Asserting reset mid-CHANGE clears state immediately. Change not yet returned is forfeited; no further r pulses occur.
- cp in IDLE, with credit 0, is a no-op.

Test Plan:
- Reset: rst=1 mid-stream → all outputs 0 asynchronously, credit=0; after release, no spurious pulses from already-held buttons until they are released and pressed again.
- Bounce: nb toggles every cycle for 3 cycles then held high 10 cycles, DB_CYCLES=4 → exactly one credit increment, credit=1, no vend.
- Exact price: nickel then dime (PRICE=3) → credit 1, then 3; s=1 one cycle later; credit=0; no r; back to IDLE.
- Change: quarter from IDLE → s pulse, credit=2, then two r pulses spaced CHANGE_GAP=2 cycles apart, credit 2→1→0, IDLE.
- Cancel: dime then cb → CHANGE with credit=2 → two r pulses, s never asserted.
- Simultaneous/blocked: nickel and dime pulses in the same cycle → credit=3 and vend; a quarter pressed during CHANGE → coin_reject one cycle, change count unchanged.

Source files
------------

// File: rtl/vending_machine_change.sv
// Coin-operated vend controller: debounced nickel/dime/quarter/cancel inputs,
// credit tracked in nickel units, change returned as spaced nickel pulses.
module vending_machine_change #(
  parameter int PRICE      = 3,
  parameter int CW         = 6,
  parameter int DB_CYCLES  = 4,
  parameter int CHANGE_GAP = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          nb,
  input  logic          db,
  input  logic          qb,
  input  logic          cb,
  output logic          s,
  output logic          r,
  output logic          coin_reject,
  output logic [CW-1:0] credit,
  output logic          busy
);

  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam int GW  = $clog2(CHANGE_GAP + 1);
  localparam logic [CW:0] PRICE_W = (CW+1)'(PRICE);

  typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

  logic [3:0] raw;
  logic [3:0] pulse;
  assign raw = {cb, qb, db, nb};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_cond
      logic           sync1_reg, sync2_reg;
      logic           vld1_reg, vld2_reg;
      logic           clean_reg, prev_reg, armed_reg;
      logic [DBW-1:0] cnt_reg;

      // armed only after a genuine low is seen, so a button held through reset stays silent
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
          vld1_reg  <= 1'b0;
          vld2_reg  <= 1'b0;
          clean_reg <= 1'b0;
          prev_reg  <= 1'b0;
          armed_reg <= 1'b0;
          cnt_reg   <= '0;
        end else begin
          sync1_reg <= raw[gi];
          sync2_reg <= sync1_reg;
          vld1_reg  <= 1'b1;
          vld2_reg  <= vld1_reg;
          prev_reg  <= clean_reg;
          if (vld2_reg && !sync2_reg) armed_reg <= 1'b1;
          if (sync2_reg != clean_reg) begin
            if (cnt_reg == DBW'(DB_CYCLES - 1)) begin
              clean_reg <= sync2_reg;
              cnt_reg   <= '0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end else begin
            cnt_reg <= '0;
          end
        end
      end

      assign pulse[gi] = clean_reg & ~prev_reg & armed_reg;
    end
  endgenerate

  logic np, dp, qp, cp;
  assign {cp, qp, dp, np} = pulse;

  logic [3:0]  vin;
  logic [CW:0] sum;
  assign vin = {3'b000, np} + {2'b00, dp, 1'b0} + {1'b0, qp, 1'b0, qp};

  state_t        state_reg, state_next;
  logic [CW-1:0] credit_reg, credit_next;
  logic [GW-1:0] gap_reg, gap_next;
  logic          s_reg, s_next;
  logic          r_reg, r_next;
  logic          rej_reg, rej_next;
  logic          busy_reg, busy_next;

  assign sum = {1'b0, credit_reg} + (CW+1)'(vin);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      credit_reg <= '0;
      gap_reg    <= '0;
      s_reg      <= 1'b0;
      r_reg      <= 1'b0;
      rej_reg    <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      credit_reg <= credit_next;
      gap_reg    <= gap_next;
      s_reg      <= s_next;
      r_reg      <= r_next;
      rej_reg    <= rej_next;
      busy_reg   <= busy_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    credit_next = credit_reg;
    gap_next    = gap_reg;
    case (state_reg)
      IDLE: begin
        if (vin != 4'd0) begin
          credit_next = CW'(vin);
          state_next  = ((CW+1)'(vin) >= PRICE_W) ? VEND : COLLECT;
        end
      end
      COLLECT: begin
        if (cp) begin
          state_next = CHANGE;
        end else if (vin != 4'd0 && !sum[CW]) begin
          credit_next = sum[CW-1:0];
          if (sum >= PRICE_W) state_next = VEND;
        end
      end
      VEND: begin
        credit_next = credit_reg - CW'(PRICE);
        state_next  = (credit_reg > CW'(PRICE)) ? CHANGE : IDLE;
      end
      CHANGE: begin
        if (r_reg) begin
          credit_next = credit_reg - 1'b1;
          gap_next    = GW'(1);
          if (credit_reg <= CW'(1)) state_next = IDLE;
        end else begin
          gap_next = gap_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    s_next    = (state_next == VEND);
    busy_next = (state_next == VEND) || (state_next == CHANGE);
    // first pulse on entry, then one every CHANGE_GAP cycles
    r_next    = (state_next == CHANGE) &&
                ((state_reg != CHANGE) || (!r_reg && gap_reg == GW'(CHANGE_GAP - 1)));
    rej_next  = 1'b0;
    case (state_reg)
      COLLECT:     rej_next = (vin != 4'd0) && (cp || sum[CW]);
      VEND, CHANGE: rej_next = (vin != 4'd0);
      default:     rej_next = 1'b0;
    endcase
  end

  assign s           = s_reg;
  assign r           = r_reg;
  assign coin_reject = rej_reg;
  assign credit      = credit_reg;
  assign busy        = busy_reg;

endmodule
